ps2_rx_fifo: RTL
================

# ps2_rx_fifo

Fully synchronous PS/2 keyboard receiver with a configurable glitch filter, odd-parity and stop-bit checking, frame timeout and a show-ahead receive FIFO. All logic runs on `clk50`. The raw `ps2_clk`/`ps2_dat` pins are oversampled rather than used as a clock. It sits between the PS/2 pins and the scan-code decoder, and replaces the single-register receiver. Scan codes are buffered so the consumer can stall for several frames without loss.

## Interface

Parameters:
- `FIFO_DEPTH`, 8, number of receive entries; must be a power of 2, minimum 2.
- `SYNC_STAGES`, 2, flip-flop stages on each pin synchronizer; minimum 2.
- `FILTER_LEN`, 4, consecutive equal synchronized samples needed to change the filtered `ps2_clk`; minimum 1.
- `TIMEOUT_CYCLES`, 50000, maximum `clk50` cycles between falling edges inside a frame (1 ms at 50 MHz).

Ports:
- `clk50`, input, 1, system clock; the only clock.
- `reset`, input, 1, synchronous, active-low.
- `ps2_clk`, input, 1, asynchronous PS/2 clock pin.
- `ps2_dat`, input, 1, asynchronous PS/2 data pin.
- `rd_en`, input, 1, pop request; acted on only when `vld`=1.
- `data`, output, 8, FIFO head byte; meaningful when `vld`=1.
- `vld`, output, 1, FIFO not empty.
- `count`, output, $clog2(FIFO_DEPTH)+1, number of stored entries.
- `overflow`, output, 1, one-cycle pulse when a good frame is dropped because the FIFO is full.
- `frame_err`, output, 1, one-cycle pulse when a frame is rejected.

## Operation

- **Synchronizers:** both pins pass through `SYNC_STAGES` flip-flops.
- **Glitch filter:**
  - `clk_f` takes the synchronized clock value once the last `FILTER_LEN` samples are all equal.
  - A falling edge means `clk_f` changes 1→0. The synchronized data is sampled in that same cycle.
- **FSM states:** IDLE, DATA, PARITY, STOP.
  - IDLE: on a falling edge with data=0 (start bit), go to DATA and clear the bit counter. A falling edge with data=1 is ignored.
  - DATA: on each falling edge, shift the data bit in LSB-first. After the 8th bit go to PARITY.
  - PARITY: on a falling edge, capture the parity bit and go to STOP.
  - STOP: on a falling edge, return to IDLE. The frame is good when stop=1 and (8 data bits + parity) has an odd number of ones. A good frame is pushed; a bad frame pulses `frame_err` and is discarded.
- **Timeout:**
  - In any state other than IDLE, a counter increments every cycle and clears on each falling edge.
  - When it reaches `TIMEOUT_CYCLES`, the FSM returns to IDLE, the partial frame is discarded and `frame_err` pulses.
  - The counter is held at 0 while in IDLE.
- **FIFO** (circular buffer, wrap-around pointers):
  - Push on a good frame.
  - Pop when `rd_en`=1 and `vld`=1. `rd_en` while empty is ignored and has no error.
  - Push while full drops the new byte and pulses `overflow`; contents are unchanged.
  - Push and pop in the same cycle while full: both are performed and `count` is unchanged; no overflow.
  - Push and pop in the same cycle while non-empty and not full: both are performed and `count` is unchanged.
  - `frame_err` and `overflow` never pulse in the same cycle.

## Timing

- **Reset values:**
  - `data`=8'h00, `vld`=0, `count`=0, `overflow`=0, `frame_err`=0.
  - FSM=IDLE, `clk_f`=1, all synchronizer stages=1.
  - FIFO pointers=0.
- Reset asserted mid-frame aborts the frame silently (no `frame_err`) and empties the FIFO.
- **Pin-to-edge latency:** a `ps2_clk` fall on the pin is detected in the FSM no later than `SYNC_STAGES`+`FILTER_LEN`+1 cycles afterwards.
- **Push:** the entry is written at the clock edge ending the detection cycle. `vld`, `data` and `count` update in the next cycle. The `overflow`/`frame_err` pulse is registered and appears in the next cycle.
- **Pop:** `data` shows the next entry in the cycle after the pop, and `count` decrements in that same cycle. Back-to-back pops are allowed every cycle.
- The FSM does not consume `rd_en`; the FIFO read path is independent of frame reception.

## Configuration

- `PS2_RX_PARITY_EN` defined:
  - A parity mismatch rejects the frame with a `frame_err` pulse.
- `PS2_RX_PARITY_EN` undefined:
  - The parity bit is captured but ignored.
  - Only stop-bit errors and timeouts cause `frame_err`.
  - Parity-check logic is not synthesized.

## Test plan

- **Single frame, 0x1C:** parity 0, stop 1, 12.5 kHz PS/2 clock → `vld` rises, `data`=0x1C, `count`=1. `rd_en` pulse → `vld`=0, `count`=0.
- **Parity error:**
  - 0xF0 with parity 1 → accepted.
  - 0xF0 with parity 0 and `PS2_RX_PARITY_EN` defined → one `frame_err` pulse, `count` stays 0.
  - Same frame with the macro undefined → 0xF0 is stored.
- **Timeout recovery:** start bit plus 3 data bits, then the clock idles high for `TIMEOUT_CYCLES`+10 cycles → one `frame_err` pulse. A following complete 0x5A frame → `data`=0x5A.
- **Overflow:** `FIFO_DEPTH`=4, frames 0x01–0x05 with no `rd_en` → `count`=4, `overflow` pulse after the 5th frame. Four pops return 0x01, 0x02, 0x03, 0x04 in order.
- **Glitch and reset:**
  - With `FILTER_LEN`=4, a 2-cycle low pulse on `ps2_clk` in IDLE with `ps2_dat` low → no state change and no later false frame.
  - `reset` low for 1 cycle after 5 bits of a frame → no `frame_err`, and the next clean 0x29 frame is received correctly.

Source files
------------

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: pin synchronizers, clock glitch filter, frame FSM with timeout, show-ahead FIFO.
// Define PS2_RX_PARITY_EN to reject frames whose odd parity does not check.
module ps2_rx_fifo #(
   parameter int FIFO_DEPTH     = 8,
   parameter int SYNC_STAGES    = 2,
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic                          clk50,
   input  logic                          reset,
   input  logic                          ps2_clk,
   input  logic                          ps2_dat,
   input  logic                          rd_en,
   output logic [7:0]                    data,
   output logic                          vld,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic                          overflow,
   output logic                          frame_err
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_DATA   = 2'd1;
   localparam logic [1:0] S_PARITY = 2'd2;
   localparam logic [1:0] S_STOP   = 2'd3;

   logic [SYNC_STAGES-1:0] clk_sync;
   logic [SYNC_STAGES-1:0] dat_sync;
   logic                   clk_s;
   logic                   dat_s;

   logic [FILTER_LEN-1:0]  clk_hist;
   logic                   clk_f;
   logic                   all_lo;
   logic                   all_hi;
   logic                   fall;

   logic [1:0]             state;
   logic [2:0]             bit_cnt;
   logic [8:0]             shreg;
   logic [TW-1:0]          tmo_cnt;
   logic                   timeout;
   logic                   frame_done;
   logic                   parity_ok;
   logic                   good;
   logic                   bad;

   logic [7:0]             mem [FIFO_DEPTH];
   logic [AW-1:0]          wr_ptr;
   logic [AW-1:0]          rd_ptr;
   logic                   full;
   logic                   pop;
   logic                   wr_en;

   // Pins idle high, so every synchronizer stage resets to 1 to avoid a false fall.
   always_ff @(posedge clk50) begin
      if (!reset) begin
         clk_sync <= '1;
         dat_sync <= '1;
      end else begin
         clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
         dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_dat};
      end
   end

   assign clk_s = clk_sync[SYNC_STAGES-1];
   assign dat_s = dat_sync[SYNC_STAGES-1];

   assign all_lo = (clk_hist == '0);
   assign all_hi = &clk_hist;

   always_ff @(posedge clk50) begin
      if (!reset) begin
         clk_hist <= '1;
         clk_f    <= 1'b1;
      end else begin
         clk_hist <= (clk_hist << 1) | FILTER_LEN'(clk_s);
         if (all_hi) begin
            clk_f <= 1'b1;
         end else if (all_lo) begin
            clk_f <= 1'b0;
         end
      end
   end

   // The fall is flagged in the cycle the filter commits to low, so data is sampled then.
   assign fall = clk_f & all_lo;

   assign timeout    = (state != S_IDLE) && (tmo_cnt == TW'(TIMEOUT_CYCLES));
   assign frame_done = (state == S_STOP) && fall && !timeout;

`ifdef PS2_RX_PARITY_EN
   assign parity_ok = ^shreg;
`else
   assign parity_ok = 1'b1;
`endif

   assign good = frame_done & dat_s & parity_ok;
   assign bad  = frame_done & ~good;

   always_ff @(posedge clk50) begin
      if (!reset) begin
         state   <= S_IDLE;
         bit_cnt <= 3'd0;
         shreg   <= 9'd0;
      end else if (timeout) begin
         state <= S_IDLE;
      end else if (fall) begin
         case (state)
            S_IDLE: begin
               if (!dat_s) begin
                  state   <= S_DATA;
                  bit_cnt <= 3'd0;
               end
            end
            S_DATA: begin
               shreg   <= {dat_s, shreg[8:1]};
               bit_cnt <= bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  state <= S_PARITY;
               end
            end
            S_PARITY: begin
               // After this shift shreg[7:0] is the byte and shreg[8] the parity bit.
               shreg <= {dat_s, shreg[8:1]};
               state <= S_STOP;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk50) begin
      if (!reset) begin
         tmo_cnt <= '0;
      end else if (state == S_IDLE || fall || timeout) begin
         tmo_cnt <= '0;
      end else begin
         tmo_cnt <= tmo_cnt + TW'(1);
      end
   end

   assign vld   = (count != '0);
   assign full  = (count == CW'(FIFO_DEPTH));
   assign pop   = rd_en & vld;
   // A pop in the same cycle frees the slot, so a full FIFO can still accept the byte.
   assign wr_en = good & (~full | pop);

   always_ff @(posedge clk50) begin
      if (wr_en) begin
         mem[wr_ptr] <= shreg[7:0];
      end
   end

   always_ff @(posedge clk50) begin
      if (!reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({wr_en, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         overflow  <= good & full & ~pop;
         frame_err <= bad | timeout;
      end
   end

   assign data = vld ? mem[rd_ptr] : 8'h00;

endmodule
